// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters, misprediction detect and stats
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_F,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        sel,
  output logic [31:0] predicted_address,
  output logic        flag,
  output logic [31:0] PCback,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [31:0]      branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] fi, ui;
  logic             fhit, uhit, train;
  logic [1:0]       ctr_d;

  assign fi   = PC_F[IDX_W+1:2];
  assign ui   = ex_pc[IDX_W+1:2];
  assign fhit = valid_q[fi] && tag_q[fi] == PC_F[31:IDX_W+2];
  assign uhit = valid_q[ui] && tag_q[ui] == ex_pc[31:IDX_W+2];

  assign sel               = fhit && ctr_q[fi][1];
  assign predicted_address = sel ? target_q[fi] : PC_F + 32'd4;
  assign PCback            = ex_pc + 32'd4;
  assign flag = ex_valid && ((ex_is_branch && ((ex_taken != ex_pred_taken) ||
                (ex_taken && ex_pred_target != ex_target))) || (!ex_is_branch && ex_pred_taken));
  assign train = ex_valid && !stall;

  always_comb begin
    ctr_d         = ex_taken ? (&ctr_q[ui] ? ctr_q[ui] : ctr_q[ui] + 2'd1)
                             : (|ctr_q[ui] ? ctr_q[ui] - 2'd1 : ctr_q[ui]);
    branch_cnt_d  = (train && ex_is_branch && ~&branch_cnt_q) ? branch_cnt_q + 32'd1 : branch_cnt_q;
    mispred_cnt_d = (train && flag && ~&mispred_cnt_q) ? mispred_cnt_q + 32'd1 : mispred_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (train && ex_is_branch && uhit) begin
        ctr_q[ui] <= ctr_d;
        if (ex_taken) target_q[ui] <= ex_target;
      end else if (train && ex_is_branch && ex_taken) begin
        valid_q[ui]  <= 1'b1;
        tag_q[ui]    <= ex_pc[31:IDX_W+2];
        target_q[ui] <= ex_target;
        ctr_q[ui]    <= 2'b10;
      end else if (train && !ex_is_branch && ex_pred_taken && uhit) begin
        valid_q[ui] <= 1'b0;
      end
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating counters. It supplies the fetch-stage next-PC mux with `predicted_address`/`sel` and produces the misprediction `flag` and recovery address `PCback` from execute-stage branch resolution. Lookup is combinational on the current fetch PC. Training happens on the clock edge from execute-stage results.

## Interface
- ENTRIES, 16, number of BTB entries; a power of two, ≥2. IDX_W = log2(ENTRIES).
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PC_F  in  32  current fetch PC (lookup address)
- stall  in  1  pipeline stall (load hazard); blocks training and statistics updates
- ex_valid  in  1  an instruction is in the execute stage
- ex_is_branch  in  1  that instruction is a conditional branch
- ex_pc  in  32  PC of the execute-stage instruction
- ex_taken  in  1  resolved branch outcome
- ex_target  in  32  resolved branch target (ALU result)
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- ex_pred_target  in  32  predicted target carried down the pipe
- sel  out  1  predict taken for PC_F
- predicted_address  out  32  predicted next PC for PC_F
- flag  out  1  misprediction detected in execute
- PCback  out  32  ex_pc + 4 (fall-through recovery address)
- branch_cnt  out  32  resolved branches, saturating
- mispred_cnt  out  32  mispredictions, saturating

## Operation
- Entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], ctr[1:0]. Index = PC[IDX_W+1:2].
- Lookup: hit = valid[idx] && tag matches PC_F.
  - On a hit with ctr[1]=1: sel=1 and predicted_address = target.
  - Otherwise: sel=0 and predicted_address = PC_F + 4 (mod 2^32).
- Misprediction: flag = ex_valid && ((ex_is_branch && ((ex_taken≠ex_pred_taken) || (ex_taken && ex_pred_target≠ex_target))) || (!ex_is_branch && ex_pred_taken)).
- flag is not gated by stall.
- PCback = ex_pc + 4 (mod 2^32) at all times.
- Training applies when ex_valid && !stall. Let ue = entry at ex_pc's index, and uhit = ue matches ex_pc.
  - Branch, uhit: ctr counts up if taken and down if not taken, saturating at 3 and 0. If taken, target ← ex_target.
  - Branch, miss, taken: allocate the entry (overwriting any occupant). valid=1, tag from ex_pc, target=ex_target, ctr=2'b10.
  - Branch, miss, not taken: no change.
  - Non-branch with ex_pred_taken and uhit: valid ← 0 (aliasing cleanup).
- Statistics:
  - branch_cnt increments on each trained branch.
  - mispred_cnt increments on each trained cycle with flag=1.
  - Both hold at 32'hFFFF_FFFF once reached.

## Timing
- Lookup and flag/PCback are purely combinational: zero latency.
- Training writes on the rising clk edge. A same-cycle lookup of the same index sees the pre-update contents; the updated entry is visible from the next cycle.
- Reset (asynchronous on rst_n falling, held while low):
  - All valid=0, all ctr=2'b01, targets/tags=0.
  - branch_cnt = mispred_cnt = 0.
  - Outputs during reset: sel=0, predicted_address=PC_F+4.
- Reset asserted mid-update: the update is discarded and the table is fully cleared.
- stall=1 for N cycles: table and counters are frozen. flag is still reported.
- PC_F = 32'hFFFF_FFFC: predicted_address wraps to 0. ex_pc = 32'hFFFF_FFFC gives PCback = 0.

## Test plan
- Reset check: after rst_n low→high with PC_F=0x100, expect sel=0, predicted_address=0x104, counters 0.
- Cold taken branch: ex_pc=0x40, taken, target 0x80, pred_taken=0. Expect flag=1 and PCback=0x44. Next cycle, PC_F=0x40 gives sel=1 and predicted_address=0x80; branch_cnt=1, mispred_cnt=1.
- Hysteresis: train 0x40 not-taken once. ctr goes 10→01, so sel=0. Train taken twice: ctr=11, sel=1. One not-taken: ctr=10, sel still 1.
- Target change: with 0x40 hit and taken but ex_target=0xC0 ≠ ex_pred_target=0x80, expect flag=1. Next cycle, predicted_address=0xC0.
- Alias and stall:
  - With 0x40 allocated (ENTRIES=16), a non-branch at ex_pc=0x40 with pred_taken=1 gives flag=1 and invalidates the entry (sel=0 next cycle).
  - The same stimulus with stall=1 leaves the table and counters unchanged.
- Saturation and wrap: preload mispred_cnt to 0xFFFF_FFFF via repeated mispredictions (or a force) and confirm it stays. PC_F=0xFFFF_FFFC gives predicted_address=0x0.
